// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: FSM states,
// default memory timeout and the canned per-stage control vectors.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERR      = 2'b10
  } state_e;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic hold;
    logic memwb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_ADVANCE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_LOADUSE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLUSH   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect (
  input  logic       memread_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       stall_o
);

  assign stall_o = memread_i & (rd_i != 5'd0) & ((rd_i == rs_i) | (rd_i == rt_i));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (memory freeze, load-use bubble,
// branch flush, sticky memory timeout). Optional counters under STALL_STATS_EN.
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       IDEX_MemRead_i,
  input  logic [4:0] IDEX_RD_i,
  input  logic [4:0] IFID_RS_i,
  input  logic [4:0] IFID_RT_i,
  input  logic       Branch_taken_i,
  input  logic       EXMEM_MemAccess_i,
  input  logic       dmem_ack_i,
  output logic       dmem_req_o,
  output logic       PC_Write_o,
  output logic       IFID_Write_o,
  output logic       IFID_Flush_o,
  output logic       IDEX_Bubble_o,
  output logic       Hold_o,
  output logic       MEMWB_Bubble_o,
  output logic       timeout_o
`ifdef STALL_STATS_EN
  ,
  output logic [31:0] memstall_cycles_o,
  output logic [31:0] loaduse_count_o
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use_s;
  logic             memstall_s;
  logic             req_s;
  logic             timeout_s;
  ctrl_t            ctrl_s;

  hazard_detect u_hazard_detect (
    .memread_i (IDEX_MemRead_i),
    .rd_i      (IDEX_RD_i),
    .rs_i      (IFID_RS_i),
    .rt_i      (IFID_RT_i),
    .stall_o   (load_use_s)
  );

  // Per-cycle control decode and next-state; reset forces the NOP vector.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_s     = CTRL_ADVANCE;
    timeout_s  = 1'b0;
    req_s      = (state_q != ERR) ? EXMEM_MemAccess_i : 1'b0;
    memstall_s = req_s & ~dmem_ack_i;
    case (state_q)
      RUN: begin
        if (memstall_s) begin
          ctrl_s  = CTRL_FREEZE;
          state_d = MEM_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (load_use_s) begin
          ctrl_s = CTRL_LOADUSE;
        end else if (Branch_taken_i) begin
          ctrl_s = CTRL_FLUSH;
        end else begin
          ctrl_s = CTRL_ADVANCE;
        end
      end
      MEM_WAIT: begin
        if (memstall_s) begin
          ctrl_s = CTRL_FREEZE;
          if (cnt_q == CNT_W'(MEM_TIMEOUT)) begin
            state_d = ERR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      ERR: begin
        ctrl_s    = CTRL_FREEZE;
        timeout_s = 1'b1;
      end
      default: begin
        ctrl_s  = CTRL_FREEZE;
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
    if (!rst_i) begin
      ctrl_s    = CTRL_RESET;
      req_s     = 1'b0;
      timeout_s = 1'b0;
    end else begin
      ctrl_s = ctrl_s;
    end
  end

  // State and wait-counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmem_req_o     = req_s;
  assign PC_Write_o     = ctrl_s.pc_write;
  assign IFID_Write_o   = ctrl_s.ifid_write;
  assign IFID_Flush_o   = ctrl_s.ifid_flush;
  assign IDEX_Bubble_o  = ctrl_s.idex_bubble;
  assign Hold_o         = ctrl_s.hold;
  assign MEMWB_Bubble_o = ctrl_s.memwb_bubble;
  assign timeout_o      = timeout_s;

`ifdef STALL_STATS_EN
  logic [31:0] memstall_cycles_q;
  logic [31:0] loaduse_count_q;
  logic        frozen_s;
  logic        lu_event_s;

  assign frozen_s   = memstall_s & (state_q != ERR);
  assign lu_event_s = (state_q == RUN) & ~memstall_s & load_use_s;

  // Saturating stall statistics.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      memstall_cycles_q <= 32'd0;
      loaduse_count_q   <= 32'd0;
    end else begin
      if (frozen_s && (memstall_cycles_q != 32'hFFFF_FFFF)) begin
        memstall_cycles_q <= memstall_cycles_q + 32'd1;
      end
      if (lu_event_s && (loaduse_count_q != 32'hFFFF_FFFF)) begin
        loaduse_count_q <= loaduse_count_q + 32'd1;
      end
    end
  end

  assign memstall_cycles_o = memstall_cycles_q;
  assign loaduse_count_o   = loaduse_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized + directed bench for pipeline_stall_ctrl against a cycle-level
// behavioural model of the stall rules.
module tb_pipeline_stall_ctrl;

  localparam int MEM_TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       IDEX_MemRead_i = 1'b0;
  logic [4:0] IDEX_RD_i = 5'd0;
  logic [4:0] IFID_RS_i = 5'd0;
  logic [4:0] IFID_RT_i = 5'd0;
  logic       Branch_taken_i = 1'b0;
  logic       EXMEM_MemAccess_i = 1'b0;
  logic       dmem_ack_i = 1'b0;
  logic       dmem_req_o, PC_Write_o, IFID_Write_o, IFID_Flush_o;
  logic       IDEX_Bubble_o, Hold_o, MEMWB_Bubble_o, timeout_o;
`ifdef STALL_STATS_EN
  logic [31:0] memstall_cycles_o, loaduse_count_o;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: frozen cycles so far in the current access, and the hung flag.
  int   m_run  = 0;
  bit   m_hung = 1'b0;
  int   m_ms_cycles = 0;
  int   m_lu_count  = 0;
  logic [7:0] m_exp;
  bit   m_ms, m_lu;

  pipeline_stall_ctrl dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .IDEX_MemRead_i    (IDEX_MemRead_i),
    .IDEX_RD_i         (IDEX_RD_i),
    .IFID_RS_i         (IFID_RS_i),
    .IFID_RT_i         (IFID_RT_i),
    .Branch_taken_i    (Branch_taken_i),
    .EXMEM_MemAccess_i (EXMEM_MemAccess_i),
    .dmem_ack_i        (dmem_ack_i),
    .dmem_req_o        (dmem_req_o),
    .PC_Write_o        (PC_Write_o),
    .IFID_Write_o      (IFID_Write_o),
    .IFID_Flush_o      (IFID_Flush_o),
    .IDEX_Bubble_o     (IDEX_Bubble_o),
    .Hold_o            (Hold_o),
    .MEMWB_Bubble_o    (MEMWB_Bubble_o),
    .timeout_o         (timeout_o)
`ifdef STALL_STATS_EN
    ,
    .memstall_cycles_o (memstall_cycles_o),
    .loaduse_count_o   (loaduse_count_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {dmem_req_o, PC_Write_o, IFID_Write_o, IFID_Flush_o,
            IDEX_Bubble_o, Hold_o, MEMWB_Bubble_o, timeout_o};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit ma, input bit ak, input bit mr, input logic [4:0] rd,
                       input logic [4:0] rs, input logic [4:0] rt, input bit br);
    EXMEM_MemAccess_i = ma;
    dmem_ack_i        = ak;
    IDEX_MemRead_i    = mr;
    IDEX_RD_i         = rd;
    IFID_RS_i         = rs;
    IFID_RT_i         = rt;
    Branch_taken_i    = br;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model and per-cycle compare, evaluated mid-cycle.
  always @(negedge clk) begin
`ifdef STALL_STATS_EN
    if (rst_i) begin
      chk("memstall_cycles", memstall_cycles_o, m_ms_cycles);
      chk("loaduse_count", loaduse_count_o, m_lu_count);
    end
`endif
    if (!rst_i) begin
      m_exp = 8'b0001_1110;
      m_run = 0;
      m_hung = 1'b0;
      m_ms_cycles = 0;
      m_lu_count = 0;
    end else if (m_hung) begin
      m_exp = 8'b0000_0111;
    end else begin
      m_ms = EXMEM_MemAccess_i && !dmem_ack_i;
      m_lu = IDEX_MemRead_i && (IDEX_RD_i != 5'd0) &&
             ((IDEX_RD_i == IFID_RS_i) || (IDEX_RD_i == IFID_RT_i));
      if (m_ms) begin
        m_exp = 8'b1000_0110;
        m_run++;
        m_ms_cycles++;
        if (m_run > MEM_TIMEOUT) m_hung = 1'b1;
      end else begin
        m_exp = {EXMEM_MemAccess_i, 7'b110_0000};
        if (m_run == 0) begin
          if (m_lu) begin
            m_exp = {EXMEM_MemAccess_i, 7'b000_1000};
            m_lu_count++;
          end else if (Branch_taken_i) begin
            m_exp = {EXMEM_MemAccess_i, 7'b111_0000};
          end
        end
        m_run = 0;
      end
    end
    chk("cycle_outputs", {24'd0, outs()}, {24'd0, m_exp});
  end

  initial begin
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    rst_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_vector", {24'd0, outs()}, 32'h1E);

    // Release: idle pipeline advances.
    next_cycle();
    rst_i = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {24'd0, outs()}, 32'h60);

    // Load-use hit for one cycle, then RD=0 gives no stall.
    next_cycle();
    drive(0, 0, 1, 5'd8, 5'd3, 5'd8, 0);
    @(negedge clk);
    chk("load_use_hit", {24'd0, outs()}, 32'h08);
    next_cycle();
    drive(0, 0, 0, 5'd8, 5'd3, 5'd8, 0);
    @(negedge clk);
    chk("load_use_one_cycle", {24'd0, outs()}, 32'h60);
    next_cycle();
    drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk);
    chk("load_use_rd_zero", {24'd0, outs()}, 32'h60);

    // Three-cycle memory wait, release on ack.
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      @(negedge clk);
      chk("mem_wait_freeze", {24'd0, outs()}, 32'h86);
    end
    next_cycle();
    drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk);
    chk("mem_wait_release", {24'd0, outs()}, 32'hE0);
    next_cycle();
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 1);
    @(negedge clk);
    chk("branch_flush", {24'd0, outs()}, 32'h70);

    // Priority: memstall beats load-use and branch; load-use beats branch.
    next_cycle();
    drive(1, 0, 1, 5'd5, 5'd5, 5'd1, 1);
    @(negedge clk);
    chk("prio_memstall", {24'd0, outs()}, 32'h86);
    next_cycle();
    drive(1, 1, 1, 5'd5, 5'd5, 5'd1, 1);
    @(negedge clk);
    chk("prio_release_no_lu", {24'd0, outs()}, 32'hE0);
    next_cycle();
    drive(0, 0, 1, 5'd5, 5'd5, 5'd1, 1);
    @(negedge clk);
    chk("prio_loaduse_over_branch", {24'd0, outs()}, 32'h08);

    // Ack exactly at the timeout cycle still recovers.
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      next_cycle();
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    end
    next_cycle();
    drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk);
    chk("ack_at_timeout_release", {24'd0, outs()}, 32'hE0);
    next_cycle();
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk);
    chk("ack_at_timeout_run", {24'd0, outs()}, 32'h60);

    // Hung memory: ERR after the wait budget, sticky until reset.
    for (int i = 0; i <= MEM_TIMEOUT; i++) begin
      next_cycle();
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(1, (i % 2) == 1, 1, 5'd2, 5'd2, 5'd2, 1);
      @(negedge clk);
      chk("err_sticky", {24'd0, outs()}, 32'h07);
    end
    next_cycle();
    rst_i = 1'b0;
    next_cycle();
    rst_i = 1'b1;
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk);
    chk("err_cleared_by_reset", {24'd0, outs()}, 32'h60);

    // Asynchronous reset in the middle of a wait (cnt=5).
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    end
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_reset_mid_wait", {24'd0, outs()}, 32'h1E);
    next_cycle();
    rst_i = 1'b1;
    drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    @(negedge clk);
    chk("after_async_reset", {24'd0, outs()}, 32'h60);

    // Randomized traffic; the memory access stays presented while frozen.
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      rst_i = ($urandom_range(0, 299) != 0);
      EXMEM_MemAccess_i = (m_run > 0 && !m_hung) ? 1'b1 : ($urandom_range(0, 2) == 0);
      dmem_ack_i        = ($urandom_range(0, 2) == 0);
      IDEX_MemRead_i    = $urandom_range(0, 1);
      IDEX_RD_i         = 5'($urandom_range(0, 3));
      IFID_RS_i         = 5'($urandom_range(0, 3));
      IFID_RT_i         = 5'($urandom_range(0, 3));
      Branch_taken_i    = ($urandom_range(0, 3) == 0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
